// File: rtl/ccff_loader.sv
// Configuration-chain programmer: serializes bitstream words MSB-first onto ccff_head
// and collects the displaced chain contents from ccff_tail as readback words.
module ccff_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 22,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              chain_shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int SC_W = $clog2(WORD_W);

    typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [SC_W-1:0]   sr_cnt_q, sr_cnt_d;
    logic              head_q, head_d;
    logic              en_q, en_d;
    logic [WORD_W-1:0] rb_sr_q, rb_sr_d;
    logic [SC_W-1:0]   rb_cnt_q, rb_cnt_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [31:0]       issued;
    logic [31:0]       take;
    logic [WORD_W-1:0] rb_acc;
    logic              last_bit;
    logic              accept;

    // Bits committed so far: already shifted, on the wire now, and still queued.
    always_comb begin
        issued    = 32'(bit_cnt_q) + 32'(en_q) + 32'(sr_cnt_q);
        take      = (32'(CHAIN_LEN) - issued < 32'(WORD_W)) ? 32'(CHAIN_LEN) - issued
                                                             : 32'(WORD_W);
        cfg_ready = (state_q == LOAD) && (issued < 32'(CHAIN_LEN)) && (sr_cnt_q == '0);
        accept    = cfg_valid && cfg_ready;
        last_bit  = en_q && (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
        rb_acc    = rb_sr_q | ({ccff_tail, {(WORD_W-1){1'b0}}} >> rb_cnt_q);
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        sr_cnt_d   = sr_cnt_q;
        head_d     = head_q;
        en_d       = 1'b0;
        rb_sr_d    = rb_sr_q;
        rb_cnt_d   = rb_cnt_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    rb_sr_d   = '0;
                    rb_cnt_d  = '0;
                end
            end
            LOAD: begin
                if (en_q) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    // A full word, or the final partial one, leaves left-aligned.
                    if ((rb_cnt_q == SC_W'(WORD_W - 1)) || last_bit) begin
                        rb_data_d  = rb_acc;
                        rb_valid_d = 1'b1;
                        rb_sr_d    = '0;
                        rb_cnt_d   = '0;
                    end else begin
                        rb_sr_d  = rb_acc;
                        rb_cnt_d = rb_cnt_q + SC_W'(1);
                    end
                    if (last_bit) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                if (sr_cnt_q != '0) begin
                    head_d   = sr_q[WORD_W-1];
                    sr_d     = sr_q << 1;
                    sr_cnt_d = sr_cnt_q - SC_W'(1);
                    en_d     = 1'b1;
                end else if (accept) begin
                    head_d   = cfg_data[WORD_W-1];
                    sr_d     = cfg_data << 1;
                    sr_cnt_d = SC_W'(take - 32'd1);
                    en_d     = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            sr_cnt_q   <= '0;
            head_q     <= 1'b0;
            en_q       <= 1'b0;
            rb_sr_q    <= '0;
            rb_cnt_q   <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            sr_cnt_q   <= sr_cnt_d;
            head_q     <= head_d;
            en_q       <= en_d;
            rb_sr_q    <= rb_sr_d;
            rb_cnt_q   <= rb_cnt_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ccff_head      = head_q;
    assign chain_shift_en = en_q;
    assign rb_data        = rb_data_q;
    assign rb_valid       = rb_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: doc/ccff_loader.md
Name: ccff_loader

Overview:
- Configuration-chain programmer; the writing end of the ccff_head/ccff_tail shift chain that runs through the logic tiles.
- Takes bitstream words over a valid/ready stream and serializes them MSB-first onto ccff_head.
- Drives a per-bit shift enable that gates prog_clk to the fabric chain.
- Captures the old chain contents emerging on ccff_tail and returns them as readback words.

Parameters:
- WORD_W, 8, width of bitstream input and readback words.
- CHAIN_LEN, 22, total configuration bits in the attached chain; must be >= 1.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- pReset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load pass; honoured only in IDLE.
- cfg_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- ccff_head  output  1  serial data into the chain head.
- chain_shift_en  output  1  chain flops shift at the next prog_clk edge; feeds the fabric clock gate.
- ccff_tail  input  1  serial data from the chain tail.
- rb_data  output  WORD_W  readback word; first-captured bit is in the MSB.
- rb_valid  output  1  one-cycle pulse; rb_data is valid. No backpressure.
- busy  output  1  high from the start acceptance until done.
- done  output  1  one-cycle pulse after the final bit shifts.

Behaviour:
- Reset values: all outputs 0. State=IDLE. Counters 0. Shift and readback registers 0.
- States:
  - IDLE: on start, go to LOAD; bit_cnt:=0, busy:=1.
  - LOAD: serialize words.
  - FINISH: one cycle; flush the partial readback word, pulse done; then return to IDLE with busy:=0.
- cfg_ready is asserted only in LOAD, and only when fewer than CHAIN_LEN bits have been issued in total (issued = bit_cnt plus bits still held in the shift register).
  - The holding shift register must be empty, or be presenting its last bit this cycle.
  - This gives back-to-back words with no bubble.
- Word acceptance: cfg_valid&cfg_ready at edge T loads the shift register. The first bit appears on ccff_head with chain_shift_en=1 in cycle T+1.
- Each cycle with chain_shift_en=1:
  - ccff_head carries exactly one bit; bit_cnt increments at the edge.
  - ccff_tail is sampled at that same edge into the readback shifter.
- Registered outputs: ccff_head and chain_shift_en are registered together.
  - If no data is available (bubble), chain_shift_en=0, ccff_head holds its previous value, and bit_cnt is frozen.
- Partial last word: when CHAIN_LEN is not a multiple of WORD_W, only the upper CHAIN_LEN mod WORD_W bits of the final word are shifted. Lower bits are discarded.
  - No further cfg_ready is asserted after the final word is accepted.
- LOAD->FINISH: on the edge where bit_cnt reaches CHAIN_LEN.
- Readback:
  - After every WORD_W captured bits, rb_valid pulses one cycle later with the word.
  - In FINISH, a partial capture is emitted left-aligned and zero-padded, with rb_valid coincident with done.
- start while busy: ignored. start in the same cycle as pReset: reset wins.
- pReset mid-pass: immediate return to IDLE with all outputs 0. The chain is left partially loaded; a new pass is needed.
- Bit count is exact: exactly CHAIN_LEN shift-enable cycles per pass, never more.

Test Plan:
- Nominal pass (WORD_W=8, CHAIN_LEN=22):
  - Stimulus: start at cycle 0; cfg_valid held with words 0xA5, 0x3C, 0xF0.
  - Required: chain_shift_en high for exactly 22 consecutive cycles. ccff_head sequence is 10100101 00111100 111100 (low 2 bits of 0xF0 dropped). done pulses the cycle after the last shift; busy falls with it.
- Readback: bench chain model (22-bit shift register) preloaded with 0x2AAAAA.
  - Required: rb words 0xAA, 0xAA, then a partial 0xA8 pulsed together with done.
  - Loading the nominal pattern a second time returns 0xA5, 0x3C, 0xF0.
- Bubble: drop cfg_valid for 3 cycles after word 1.
  - Required: chain_shift_en=0 for those 3 cycles; ccff_head is stable; still exactly 22 shifts total with an unchanged bit sequence.
- start asserted mid-LOAD.
  - Required: ignored; no counter reset; the pass completes normally.
- pReset after 10 shifts.
  - Required: all outputs 0 immediately, state IDLE. A fresh start then completes a full 22-shift pass.
- CHAIN_LEN=16 (exact multiple).
  - Required: 2 words accepted, no third cfg_ready. rb_valid pulses twice, the second pulse one cycle after the last shift; no zero-padded partial word is emitted.
